// File: rtl/pdm_serializer.sv
// PDM transmit serializer: one-word-ahead holding register feeding a shift register
// that emits one bit per sampling period. Optional SERIALIZER_SIGMA_DELTA_EN macro.
module pdm_serializer #(
  parameter int WORD_LENGTH        = 16,
  parameter int SYSTEM_FREQUENCY   = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [WORD_LENGTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   pdm_data_o,
  output logic                   pdm_clk_o,
  output logic                   audio_sd_o,
  output logic                   underrun_o
);

  localparam int DIVIDE = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
  localparam int DIV_W  = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int IDX_W  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDE - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIVIDE / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [WORD_LENGTH-1:0] hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [WORD_LENGTH-1:0] active_q, active_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
  logic                   pdm_data_q, pdm_data_d;
  logic                   pdm_clk_q, pdm_clk_d;
  logic                   audio_sd_q, audio_sd_d;
  logic                   underrun_q, underrun_d;

  logic                   tick;
  logic                   load;
  logic                   emit;
  logic                   emit_bit;
  logic [WORD_LENGTH-1:0] next_word;

`ifdef SERIALIZER_SIGMA_DELTA_EN
  localparam logic [WORD_LENGTH-1:0] MSB_MASK = {1'b1, {(WORD_LENGTH-1){1'b0}}};
  logic [WORD_LENGTH-1:0] acc_q, acc_d;
  logic [WORD_LENGTH:0]   sum;
`endif

  assign ready_o    = ~hold_valid_q;
  assign pdm_data_o = pdm_data_q;
  assign pdm_clk_o  = pdm_clk_q;
  assign audio_sd_o = audio_sd_q;
  assign underrun_o = underrun_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    active_d     = active_q;
    bit_idx_d    = bit_idx_q;
    div_cnt_d    = div_cnt_q;
    pdm_data_d   = pdm_data_q;
    underrun_d   = 1'b0;
    tick         = (div_cnt_q == DIV_LAST);
    load         = 1'b0;
    emit         = 1'b0;
    next_word    = active_q;

    unique case (state_q)
      ST_IDLE: begin
        div_cnt_d = '0;
        load      = hold_valid_q;
      end
      ST_RUN: begin
        if (tick) begin
          div_cnt_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            load = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            emit      = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: ;
    endcase

    // A word boundary with nothing buffered sends silence rather than stalling the line.
    if (load) begin
      emit      = 1'b1;
      bit_idx_d = '0;
      div_cnt_d = '0;
      state_d   = ST_RUN;
      if (hold_valid_q) begin
        next_word    = hold_q;
        hold_valid_d = 1'b0;
      end else begin
        next_word  = '0;
        underrun_d = 1'b1;
      end
      active_d = next_word;
    end

    if (valid_i && !hold_valid_q) begin
      hold_d       = data_i;
      hold_valid_d = 1'b1;
    end

`ifdef SERIALIZER_SIGMA_DELTA_EN
    acc_d    = acc_q;
    sum      = {1'b0, acc_q} + {1'b0, next_word ^ MSB_MASK};
    emit_bit = sum[WORD_LENGTH];
    if (emit) acc_d = sum[WORD_LENGTH-1:0];
`else
    emit_bit = next_word[bit_idx_d];
`endif

    if (emit) pdm_data_d = emit_bit;
    pdm_clk_d  = (div_cnt_d >= DIV_HALF);
    audio_sd_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock_i) begin
    // NOTE: word registers are not reset; hold_valid_q and the load path gate every use of them.
    hold_q   <= hold_d;
    active_q <= active_d;
    if (reset_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= ST_IDLE;
      hold_valid_q <= 1'b0;
      bit_idx_q    <= '0;
      div_cnt_q    <= '0;
      pdm_data_q   <= 1'b0;
      pdm_clk_q    <= 1'b0;
      audio_sd_q   <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef SERIALIZER_SIGMA_DELTA_EN
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      bit_idx_q    <= bit_idx_d;
      div_cnt_q    <= div_cnt_d;
      pdm_data_q   <= pdm_data_d;
      pdm_clk_q    <= pdm_clk_d;
      audio_sd_q   <= audio_sd_d;
      underrun_q   <= underrun_d;
`ifdef SERIALIZER_SIGMA_DELTA_EN
      acc_q        <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pdm_serializer.sv
// Self-checking bench for pdm_serializer: directed scenarios with literal expectations
// plus randomized traffic, all outputs compared each cycle against a slot-position model.
module tb_pdm_serializer;

  localparam int WL  = 16;
  localparam int DIV = 4;
  localparam int SLOT = WL * DIV;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic [WL-1:0] data_i;
  logic          valid_i;
  logic          ready_o, pdm_data_o, pdm_clk_o, audio_sd_o, underrun_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pdm_serializer #(
    .WORD_LENGTH       (WL),
    .SYSTEM_FREQUENCY  (100000000),
    .SAMPLING_FREQUENCY(25000000)
  ) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .pdm_data_o(pdm_data_o),
    .pdm_clk_o (pdm_clk_o),
    .audio_sd_o(audio_sd_o),
    .underrun_o(underrun_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the line position inside the current word slot, counted from the load cycle.
  logic          m_valid = 1'b0;
  logic          m_run, m_hold_valid, hv_old, m_load;
  logic [WL-1:0] m_hold, m_word, m_acc;
  logic [WL:0]   m_sum;
  int            m_p, p_next;
  logic          e_data, e_clk, e_sd, e_under, e_ready;

  always @(posedge clock_i) begin
    if (reset_i) begin
      m_run = 0; m_hold_valid = 0; m_acc = '0; m_p = 0;
      e_data = 0; e_clk = 0; e_sd = 0; e_under = 0;
    end else begin
      hv_old  = m_hold_valid;
      m_load  = 0;
      e_under = 0;
      p_next  = 0;
      if (!m_run) begin
        m_load = hv_old;
      end else begin
        p_next = (m_p + 1) % SLOT;
        m_load = (p_next == 0);
      end
      if (m_load) begin
        if (hv_old) m_word = m_hold;
        else begin m_word = '0; e_under = 1; end
        m_hold_valid = 0;
        m_run = 1;
      end
      if (m_run) begin
        m_p = p_next;
        if (m_p % DIV == 0) begin
`ifdef SERIALIZER_SIGMA_DELTA_EN
          m_sum  = {1'b0, m_acc} + {1'b0, m_word ^ 16'h8000};
          e_data = m_sum[WL];
          m_acc  = m_sum[WL-1:0];
`else
          e_data = m_word[m_p / DIV];
`endif
        end
        e_clk = ((m_p % DIV) >= DIV / 2);
        e_sd  = 1;
      end
      if (valid_i && !hv_old) begin
        m_hold = data_i;
        m_hold_valid = 1;
      end
    end
    e_ready = !m_hold_valid;
    m_valid = 1;
  end

  always @(negedge clock_i) begin
    if (m_valid) begin
      check("pdm_data", 32'(pdm_data_o), 32'(e_data));
      check("pdm_clk",  32'(pdm_clk_o),  32'(e_clk));
      check("audio_sd", 32'(audio_sd_o), 32'(e_sd));
      check("underrun", 32'(underrun_o), 32'(e_under));
      check("ready",    32'(ready_o),    32'(e_ready));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1; valid_i = 0;
    step(2);
    reset_i = 0;
  endtask

  // Called in the cycle showing bit 0; samples each bit at its first cycle.
  task automatic capture_word(output logic [WL-1:0] v, output logic [3:0] clk_pat);
    v = '0; clk_pat = '0;
    for (int i = 0; i < WL; i++) begin
      for (int ph = 0; ph < DIV; ph++) begin
        if (ph == 0) v[i] = pdm_data_o;
        if (i == 0) clk_pat[ph] = pdm_clk_o;
        step(1);
      end
    end
  endtask

  task automatic send_and_capture(input logic [WL-1:0] w, output logic [WL-1:0] v);
    logic [3:0] cp;
    do_reset();
    valid_i = 1; data_i = w;
    step(1);
    valid_i = 0;
    step(1);
    capture_word(v, cp);
  endtask

  initial begin
    logic [WL-1:0] word_v;
    logic [3:0]    clk_v;
    int            n_under, n_ones, pct;

    reset_i = 1; valid_i = 0; data_i = '0;
    step(3);
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_outs", 32'({pdm_data_o, pdm_clk_o, audio_sd_o, underrun_o}), 32'd0);
    reset_i = 0;

    // First word from reset, then silence, then an accept exactly on a load cycle.
    valid_i = 1; data_i = 16'hA5F0;
    step(1);
    valid_i = 0;
    check("first_ready_low", 32'(ready_o), 32'd0);
    check("first_sd_low", 32'(audio_sd_o), 32'd0);
    step(1);
    check("first_ready_back", 32'(ready_o), 32'd1);
    check("first_sd_high", 32'(audio_sd_o), 32'd1);
    capture_word(word_v, clk_v);
`ifndef SERIALIZER_SIGMA_DELTA_EN
    check("raw_A5F0", 32'(word_v), 32'h0000A5F0);
`endif
    check("clk_pattern", 32'(clk_v), 32'h0000000C);
    n_under = 0; n_ones = 0;
    for (int c = 0; c < 3 * SLOT; c++) begin
      n_under += int'(underrun_o);
      n_ones  += int'(pdm_data_o);
      step(1);
    end
    check("underrun_count", 32'(n_under), 32'd3);
`ifdef SERIALIZER_SIGMA_DELTA_EN
    check("silence_density", 32'(n_ones), 32'd96);
`else
    check("silence_zero", 32'(n_ones), 32'd0);
`endif
    step(SLOT - 1);
    valid_i = 1; data_i = 16'h3C5A;
    step(1);
    valid_i = 0;
    check("boundary_underrun", 32'(underrun_o), 32'd1);
    check("boundary_held", 32'(ready_o), 32'd0);
    step(SLOT);
    check("boundary_loaded", 32'(underrun_o), 32'd0);
    check("boundary_ready", 32'(ready_o), 32'd1);

    // Back-to-back words with valid held high.
    do_reset();
    valid_i = 1; data_i = 16'h0001;
    step(1);
    data_i = 16'h8000;
    check("b2b_full", 32'(ready_o), 32'd0);
    step(1);
    check("b2b_ready", 32'(ready_o), 32'd1);
    step(1);
    valid_i = 0;
    n_under = 0;
    for (int c = 0; c < 62; c++) begin
      n_under += int'(underrun_o);
      step(1);
    end
    check("b2b_hold_full", 32'(ready_o), 32'd0);
    step(1);
    check("b2b_ready_after_load", 32'(ready_o), 32'd1);
    for (int c = 0; c < SLOT; c++) begin
      n_under += int'(underrun_o);
      step(1);
    end
    check("b2b_no_underrun", 32'(n_under), 32'd0);
    check("b2b_tail_underrun", 32'(underrun_o), 32'd1);

    // Reset during bit 7, then a fresh word must start at bit 0.
    do_reset();
    valid_i = 1; data_i = 16'hFFFF;
    step(1);
    valid_i = 0;
    step(30);
    reset_i = 1;
    step(1);
    check("midreset_outs", 32'({pdm_data_o, pdm_clk_o, audio_sd_o, underrun_o}), 32'd0);
    check("midreset_ready", 32'(ready_o), 32'd1);
    reset_i = 0;
    valid_i = 1; data_i = 16'h00FF;
    step(1);
    valid_i = 0;
    step(1);
    check("restart_sd", 32'(audio_sd_o), 32'd1);
`ifdef SERIALIZER_SIGMA_DELTA_EN
    check("restart_bit0", 32'(pdm_data_o), 32'd0);
    send_and_capture(16'h0000, word_v);
    check("sd_0000", 32'(word_v), 32'h0000AAAA);
    send_and_capture(16'h8000, word_v);
    check("sd_8000", 32'(word_v), 32'h00000000);
    send_and_capture(16'h7FFF, word_v);
    check("sd_7FFF", 32'(word_v), 32'h0000FFFE);
`else
    check("restart_bit0", 32'(pdm_data_o), 32'd1);
    send_and_capture(16'h8001, word_v);
    check("raw_8001", 32'(word_v), 32'h00008001);
`endif

    // Randomized traffic with varying offered load and rare resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      pct = (((c / 300) % 3) == 0) ? 10 : ((((c / 300) % 3) == 1) ? 60 : 100);
      valid_i = ($urandom_range(0, 99) < pct);
      data_i  = WL'($urandom);
      reset_i = ($urandom_range(0, 999) == 0);
      step(1);
    end
    valid_i = 0; reset_i = 0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_serializer.md
# pdm_serializer

Transmit-side counterpart of the PDM microphone deserializer. Accepts 16-bit words over a valid/ready handshake, buffers one word ahead, and shifts them out one bit per sampling period on a 1-bit PDM line with a companion bit clock. Sits between the audio processing path and the board's mono audio output (PDM/PWM jack plus amplifier shutdown pin).

## Interface
- WORD_LENGTH, 16: bits per word; also the sigma-delta accumulator width.
- SYSTEM_FREQUENCY, 100000000: clock_i frequency in Hz.
- SAMPLING_FREQUENCY, 1000000: output bit rate in Hz. DIVIDE = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY (integer division), must be ≥ 2.

Ports:
- clock_i  in  1  system clock; the only clock.
- reset_i  in  1  reset, synchronous, active-high.
- data_i  in  WORD_LENGTH  word to transmit.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  holding register empty; transfer occurs when valid_i && ready_o.
- pdm_data_o  out  1  serial PDM bit, registered.
- pdm_clk_o  out  1  bit clock, registered.
- audio_sd_o  out  1  amplifier enable; high once running.
- underrun_o  out  1  one-cycle pulse when a word boundary finds no buffered word.

## Operation
- Storage: holding register (hold, hold_valid) and active shift register (active, bit_idx 0..WORD_LENGTH-1), divider counter div_cnt 0..DIVIDE-1, run flag.
- ready_o = ~hold_valid (combinational). An accepted word goes into hold only, never directly into active.
- IDLE (run=0, after reset): div_cnt held at 0; pdm_data_o=0, pdm_clk_o=0, audio_sd_o=0. The first cycle with hold_valid=1 is a load cycle: active←hold, hold_valid←0, bit_idx←0, div_cnt←0, run←1.
- RUN: div_cnt increments each cycle. A tick is div_cnt==DIVIDE-1. On a tick with bit_idx<WORD_LENGTH-1: div_cnt←0, bit_idx++, next bit is emitted. On a tick with bit_idx==WORD_LENGTH-1, the cycle is a load cycle.
- Load cycle in RUN: uses hold_valid as registered before this cycle. If set, load from hold. If clear, load silence (all-zero word) and pulse underrun_o; run stays 1. A word accepted in that same cycle stays in hold for the next boundary.
- Bit emission: on every load cycle and on every non-final tick, pdm_data_o ← the current bit, taken from bit_idx of the newly indexed word. Bits go LSB first (bit 0 first).
- RUN never returns to IDLE except through reset_i.
- pdm_clk_o ← 1 when the next div_cnt ≥ DIVIDE/2, else 0. This gives a rising edge mid-bit; the receiver samples on the rising edge.

## Timing
- Reset values: pdm_data_o=0, pdm_clk_o=0, audio_sd_o=0, underrun_o=0, ready_o=1, hold_valid=0, run=0, accumulator=0. reset_i mid-word aborts immediately and drops both the hold word and the active word.
- First word: accepted in cycle A, loaded in A+1, bit 0 visible on pdm_data_o from A+2. audio_sd_o rises in A+2.
- Each bit stays on pdm_data_o for exactly DIVIDE cycles. Each word occupies WORD_LENGTH×DIVIDE cycles with no gap between words.
- ready_o rises the cycle after a load empties hold.
- underrun_o is high in the cycle after the failing load cycle, for one cycle only.

## Configuration
- SERIALIZER_SIGMA_DELTA_EN defined: each word is a signed two's-complement PCM sample.
  - u = word with MSB inverted.
  - Each emitted bit: sum = acc[WORD_LENGTH-1:0] + u (WORD_LENGTH+1 bits); bit = sum[WORD_LENGTH]; acc ← sum.
  - The accumulator persists across words and is cleared only by reset. Underrun silence (0) produces a 50% density stream.
- Not defined: raw mode. The emitted bit is active[bit_idx], the exact inverse of the deserializer, and no accumulator is instantiated.

## Test plan
- Use SAMPLING_FREQUENCY=25000000 (DIVIDE=4) throughout.
- Raw mode: send 16'hA5F0 from reset. Response: ready_o low 1 cycle; pdm_data_o reads 0000 1111 1010 0101 (LSB first), each bit held 4 cycles; audio_sd_o high from cycle A+2; pdm_clk_o 0,0,1,1 per bit.
- Back-to-back: drive valid_i continuously with 16'h0001, 16'h8000. Response: the two words are contiguous with no gap and no underrun; ready_o drops while hold is full and rises the cycle after each load.
- Underrun: send one word then hold valid_i low. Response: underrun_o pulses once per 64-cycle word boundary; raw pdm_data_o=0 for the silence words.
- Sigma-delta: sample 16'h0000 gives 0,1,0,1…; 16'h8000 gives all zeros; 16'h7FFF gives bit 0 = 0 then 15 ones in the first word.
- Reset mid-word: assert reset_i at bit 7 of a word. Response: the next cycle shows all outputs at reset values, the accumulator cleared, and ready_o=1. The next accepted word starts at bit 0.
- Boundary accept: assert valid_i exactly on a load cycle with hold empty. Response: underrun_o pulses; the word is transmitted in the following slot.
